// File: rtl/cpu_core_pkg.sv
// Shared constants and FSM encoding for the interrupt controller.
package cpu_core_pkg;
    localparam int unsigned NUM_LINES = 16;
    localparam int unsigned VEC_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_ASK,
        ST_HOLD
    } irq_state_e;

    // Vector table entry address; 32-bit wrap-around is intended.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [7:0] num);
        return base + (32'(num) << VEC_SHIFT);
    endfunction
endpackage

// File: rtl/interrupt_ctrl_if.sv
// Interrupt controller bus: interrupt sources, mask port, pipeline handshake, grant outputs.
// With SOFT_IRQ_EN defined, the software interrupt request signals are added.
interface interrupt_ctrl_if;
    logic [cpu_core_pkg::NUM_LINES-1:0] irq_line;
    logic                               mask_wr;
    logic [cpu_core_pkg::NUM_LINES-1:0] mask_wdata;
    logic [31:0]                        sys;
    logic                               pc_stop;
    logic                               this_isRunning;
    logic [31:0]                        thisOrderAddress;
    logic                               interrupt_ask;
    logic [31:0]                        interrupt_pc;
    logic [31:0]                        interrupt_ipc;
    logic [7:0]                         interrupt_num;
    logic [cpu_core_pkg::NUM_LINES-1:0] pending;
`ifdef SOFT_IRQ_EN
    logic                               sw_irq;
    logic [7:0]                         sw_irq_num;
`endif

    modport slave (
        input  irq_line, mask_wr, mask_wdata, sys, pc_stop, this_isRunning, thisOrderAddress,
`ifdef SOFT_IRQ_EN
        input  sw_irq, sw_irq_num,
`endif
        output interrupt_ask, interrupt_pc, interrupt_ipc, interrupt_num, pending
    );

    modport master (
        output irq_line, mask_wr, mask_wdata, sys, pc_stop, this_isRunning, thisOrderAddress,
`ifdef SOFT_IRQ_EN
        output sw_irq, sw_irq_num,
`endif
        input  interrupt_ask, interrupt_pc, interrupt_ipc, interrupt_num, pending
    );
endinterface

// File: rtl/irq_prio_enc16.sv
// Lowest-index-wins priority encoder over the 16 eligible interrupt lines.
module irq_prio_enc16
    import cpu_core_pkg::*;
(
    input  logic [NUM_LINES-1:0] req_i,
    output logic                 valid_o,
    output logic [3:0]           idx_o
);
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = 4'(i);
        end
    end
endmodule

// File: rtl/interrupt_ctrl.sv
// Edge-triggered 16-line interrupt controller with masking, safe-point arming and grant hold-off.
// Optional software interrupt source enabled by defining SOFT_IRQ_EN.
module interrupt_ctrl
    import cpu_core_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100,
    parameter int unsigned HOLDOFF  = 2
) (
    input  logic            clk,
    input  logic            all_rst_n,
    interrupt_ctrl_if.slave bus
);
    // The IDLE cycle after HOLD is part of the blocked window, so HOLD itself lasts HOLDOFF-1 cycles.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    irq_state_e           state_q, state_d;
    logic [NUM_LINES-1:0] irq_q, pend_q, pend_d, mask_q, mask_d, clr, elig;
    logic [7:0]           hold_q, hold_d, sel_q, sel_d, num_q, num_d;
    logic [31:0]          pc_q, pc_d, ipc_q, ipc_d;
    logic                 enc_vld, any_elig, take, sel_line;
    logic [3:0]           enc_idx;
    logic [7:0]           win_num;
    logic                 unused_sys;

    assign unused_sys = ^bus.sys[31:1];
    assign elig       = pend_q & mask_q;

    irq_prio_enc16 u_enc (.req_i(elig), .valid_o(enc_vld), .idx_o(enc_idx));

    assign take = (state_q == ST_IDLE) && any_elig && bus.sys[0];

`ifdef SOFT_IRQ_EN
    logic       sw_pend_q, sw_pend_d, sel_sw_q, sel_sw_d;
    logic [7:0] sw_num_q, sw_num_d;

    assign any_elig = enc_vld | sw_pend_q;
    assign win_num  = enc_vld ? {4'h0, enc_idx} : sw_num_q;
    assign sel_line = !sel_sw_q;

    // A new request in the ASK cycle survives the clear.
    always_comb begin
        sel_sw_d  = take ? !enc_vld : sel_sw_q;
        sw_pend_d = (sw_pend_q & !(state_q == ST_ASK && sel_sw_q)) | bus.sw_irq;
        sw_num_d  = bus.sw_irq ? bus.sw_irq_num : sw_num_q;
    end

    always_ff @(posedge clk or negedge all_rst_n) begin
        if (!all_rst_n) begin
            sw_pend_q <= 1'b0;
            sel_sw_q  <= 1'b0;
            sw_num_q  <= '0;
        end else begin
            sw_pend_q <= sw_pend_d;
            sel_sw_q  <= sel_sw_d;
            sw_num_q  <= sw_num_d;
        end
    end
`else
    assign any_elig = enc_vld;
    assign win_num  = {4'h0, enc_idx};
    assign sel_line = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        num_d   = num_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        clr     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    sel_d   = win_num;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!bus.sys[0]) begin
                    state_d = ST_IDLE;
                end else if (!bus.pc_stop && bus.this_isRunning) begin
                    ipc_d   = bus.thisOrderAddress;
                    num_d   = sel_q;
                    pc_d    = vec_addr(VEC_BASE, sel_q);
                    state_d = ST_ASK;
                end
            end
            ST_ASK: begin
                if (sel_line) clr[sel_q[3:0]] = 1'b1;
                if (HOLDOFF > 1) begin
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_q <= 8'd1) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
        endcase
    end

    assign pend_d = (pend_q & ~clr) | (bus.irq_line & ~irq_q);
    assign mask_d = bus.mask_wr ? bus.mask_wdata : mask_q;

    always_ff @(posedge clk or negedge all_rst_n) begin
        if (!all_rst_n) begin
            state_q <= ST_IDLE;
            irq_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
            hold_q  <= '0;
            sel_q   <= '0;
            num_q   <= '0;
            pc_q    <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= bus.irq_line;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            num_q   <= num_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
        end
    end

    assign bus.interrupt_ask = (state_q == ST_ASK);
    assign bus.interrupt_pc  = pc_q;
    assign bus.interrupt_ipc = ipc_q;
    assign bus.interrupt_num = num_q;
    assign bus.pending       = pend_q;
endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed scenarios plus a randomized run against a timeline-level reference model.
module tb_interrupt_ctrl;
    localparam logic [31:0] VEC_BASE = 32'h0000_0100;
    localparam int          HOLDOFF  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    interrupt_ctrl_if bus();

    interrupt_ctrl #(.VEC_BASE(VEC_BASE), .HOLDOFF(HOLDOFF)) dut (
        .clk      (clk),
        .all_rst_n(rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irq_line         = '0;
        bus.mask_wr          = 1'b0;
        bus.mask_wdata       = '0;
        bus.sys              = 32'h1;
        bus.pc_stop          = 1'b0;
        bus.this_isRunning   = 1'b1;
        bus.thisOrderAddress = '0;
`ifdef SOFT_IRQ_EN
        bus.sw_irq           = 1'b0;
        bus.sw_irq_num       = '0;
`endif
    endtask

    task automatic settle();
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++; if (bus.interrupt_ask !== 1'b0) begin errors++; $display("FAIL reset_ask: got %b expected 0", bus.interrupt_ask); end
        checks++; if (bus.interrupt_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.interrupt_pc); end
        checks++; if (bus.interrupt_ipc !== 32'h0) begin errors++; $display("FAIL reset_ipc: got %h expected 0", bus.interrupt_ipc); end
        checks++; if (bus.interrupt_num !== 8'h0) begin errors++; $display("FAIL reset_num: got %h expected 0", bus.interrupt_num); end
        checks++; if (bus.pending !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", bus.pending); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.pending !== 16'h0) begin errors++; $display("FAIL reset_release_pending: got %h expected 0", bus.pending); end
    endtask

    task automatic test_single_grant();
        int at;
        settle();
        at = -1;
        bus.irq_line = 16'h0008;
        bus.thisOrderAddress = 32'h0000_2000;
        tick();
        checks++; if (bus.pending !== 16'h0008) begin errors++; $display("FAIL single_pending_set: got %h expected 0008", bus.pending); end
        for (int k = 1; k <= 8 && at < 0; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1) begin
                at = k;
                checks++; if (bus.interrupt_num !== 8'd3) begin errors++; $display("FAIL single_num: got %0d expected 3", bus.interrupt_num); end
                checks++; if (bus.interrupt_pc !== 32'h0000_010C) begin errors++; $display("FAIL single_pc: got %h expected 0000010c", bus.interrupt_pc); end
                checks++; if (bus.interrupt_ipc !== 32'h0000_2000) begin errors++; $display("FAIL single_ipc: got %h expected 00002000", bus.interrupt_ipc); end
            end
        end
        checks++; if (at !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", at); end
        tick();
        checks++; if (bus.interrupt_ask !== 1'b0) begin errors++; $display("FAIL single_ask_width: got %b expected 0", bus.interrupt_ask); end
        checks++; if (bus.pending !== 16'h0) begin errors++; $display("FAIL single_pending_clear: got %h expected 0", bus.pending); end
    endtask

    task automatic test_simultaneous();
        int         at[2];
        logic [7:0] nm[2];
        int         got;
        settle();
        got = 0;
        at  = '{-1, -1};
        nm  = '{8'hFF, 8'hFF};
        bus.irq_line = 16'h0024;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1 && got < 2) begin
                at[got] = k;
                nm[got] = bus.interrupt_num;
                got++;
            end
        end
        checks++; if (at[0] !== 2) begin errors++; $display("FAIL simul_first_at: got %0d expected 2", at[0]); end
        checks++; if (nm[0] !== 8'd2) begin errors++; $display("FAIL simul_first_num: got %0d expected 2", nm[0]); end
        checks++; if (at[1] !== 2 + HOLDOFF + 2) begin errors++; $display("FAIL simul_second_at: got %0d expected %0d", at[1], 2 + HOLDOFF + 2); end
        checks++; if (nm[1] !== 8'd5) begin errors++; $display("FAIL simul_second_num: got %0d expected 5", nm[1]); end
        checks++; if (bus.pending !== 16'h0) begin errors++; $display("FAIL simul_pending: got %h expected 0", bus.pending); end
    endtask

    task automatic test_stall();
        int asks;
        settle();
        asks = 0;
        bus.pc_stop = 1'b1;
        bus.thisOrderAddress = 32'hDEAD_0000;
        bus.irq_line = 16'h0080;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1) asks++;
        end
        checks++; if (asks !== 0) begin errors++; $display("FAIL stall_no_ask: got %0d asks expected 0", asks); end
        bus.pc_stop = 1'b0;
        bus.thisOrderAddress = 32'h0001_0040;
        tick();
        checks++; if (bus.interrupt_ask !== 1'b1) begin errors++; $display("FAIL stall_ask: got %b expected 1", bus.interrupt_ask); end
        checks++; if (bus.interrupt_ipc !== 32'h0001_0040) begin errors++; $display("FAIL stall_ipc: got %h expected 00010040", bus.interrupt_ipc); end
        checks++; if (bus.interrupt_pc !== 32'h0000_011C) begin errors++; $display("FAIL stall_pc: got %h expected 0000011c", bus.interrupt_pc); end
    endtask

    task automatic test_masking();
        int asks;
        int at;
        settle();
        asks = 0;
        at   = -1;
        bus.mask_wr = 1'b1;
        bus.mask_wdata = 16'h0000;
        tick();
        bus.mask_wr = 1'b0;
        bus.irq_line = 16'h0001;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1) asks++;
        end
        checks++; if (asks !== 0) begin errors++; $display("FAIL mask_no_ask: got %0d asks expected 0", asks); end
        checks++; if (bus.pending !== 16'h0001) begin errors++; $display("FAIL mask_pending: got %h expected 0001", bus.pending); end
        bus.mask_wr = 1'b1;
        bus.mask_wdata = 16'h0001;
        tick();
        bus.mask_wr = 1'b0;
        for (int k = 1; k <= 8 && at < 0; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1) begin
                at = k;
                checks++; if (bus.interrupt_num !== 8'd0) begin errors++; $display("FAIL mask_num: got %0d expected 0", bus.interrupt_num); end
                checks++; if (bus.interrupt_pc !== 32'h0000_0100) begin errors++; $display("FAIL mask_pc: got %h expected 00000100", bus.interrupt_pc); end
            end
        end
        checks++; if (at !== 2) begin errors++; $display("FAIL mask_unmask_latency: got %0d expected 2", at); end
        bus.mask_wr = 1'b1;
        bus.mask_wdata = 16'hFFFF;
        tick();
        bus.mask_wr = 1'b0;
    endtask

    task automatic test_global_disable();
        int asks;
        int at;
        settle();
        asks = 0;
        at   = -1;
        bus.irq_line = 16'h0200;
        tick();
        tick();
        bus.sys = 32'h0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1) asks++;
        end
        checks++; if (asks !== 0) begin errors++; $display("FAIL gdis_no_ask: got %0d asks expected 0", asks); end
        checks++; if (bus.pending !== 16'h0200) begin errors++; $display("FAIL gdis_pending: got %h expected 0200", bus.pending); end
        checks++; if (bus.interrupt_num !== 8'd0) begin errors++; $display("FAIL gdis_num_stable: got %0d expected 0", bus.interrupt_num); end
        checks++; if (bus.interrupt_pc !== 32'h0000_0100) begin errors++; $display("FAIL gdis_pc_stable: got %h expected 00000100", bus.interrupt_pc); end
        bus.sys = 32'h1;
        for (int k = 1; k <= 8 && at < 0; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1) begin
                at = k;
                checks++; if (bus.interrupt_num !== 8'd9) begin errors++; $display("FAIL gdis_resume_num: got %0d expected 9", bus.interrupt_num); end
                checks++; if (bus.interrupt_pc !== 32'h0000_0124) begin errors++; $display("FAIL gdis_resume_pc: got %h expected 00000124", bus.interrupt_pc); end
            end
        end
        checks++; if (at < 0) begin errors++; $display("FAIL gdis_resume: got no ask expected one within 8 cycles"); end
    endtask

    task automatic test_reset_mid();
        int asks;
        settle();
        asks = 0;
        bus.pc_stop = 1'b1;
        bus.irq_line = 16'h0010;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.interrupt_ask !== 1'b0) begin errors++; $display("FAIL rmid_ask: got %b expected 0", bus.interrupt_ask); end
        checks++; if (bus.interrupt_pc !== 32'h0) begin errors++; $display("FAIL rmid_pc: got %h expected 0", bus.interrupt_pc); end
        checks++; if (bus.interrupt_ipc !== 32'h0) begin errors++; $display("FAIL rmid_ipc: got %h expected 0", bus.interrupt_ipc); end
        checks++; if (bus.interrupt_num !== 8'h0) begin errors++; $display("FAIL rmid_num: got %h expected 0", bus.interrupt_num); end
        checks++; if (bus.pending !== 16'h0) begin errors++; $display("FAIL rmid_pending: got %h expected 0", bus.pending); end
        bus.irq_line = '0;
        bus.pc_stop = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.interrupt_ask === 1'b1) asks++;
        end
        checks++; if (asks !== 0) begin errors++; $display("FAIL rmid_no_ask: got %0d asks expected 0", asks); end
        checks++; if (bus.pending !== 16'h0) begin errors++; $display("FAIL rmid_pending_after: got %h expected 0", bus.pending); end
    endtask

    // Model view: a selected request waits for a safe point, then grants; after a grant no new
    // selection may happen until HOLDOFF cycles have elapsed.
    task automatic test_random();
        logic [15:0] m_pend, m_mask, m_prev, clr, e;
        logic [7:0]  m_num;
        logic [31:0] m_pc, m_ipc;
        logic        m_ask, m_wait, nx_ask;
        int          m_sel, m_free;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_pend = '0; m_mask = 16'hFFFF; m_prev = '0; m_num = '0; m_pc = '0; m_ipc = '0;
        m_ask = 1'b0; m_wait = 1'b0; m_sel = 0; m_free = 0;
        for (int n = 0; n < 400; n++) begin
            bus.irq_line         = bus.irq_line ^ 16'($urandom & $urandom & $urandom);
            bus.mask_wr          = ($urandom_range(0, 15) == 0);
            bus.mask_wdata       = 16'($urandom | $urandom);
            bus.sys              = {31'($urandom), ($urandom_range(0, 7) != 0)};
            bus.pc_stop          = ($urandom_range(0, 3) == 0);
            bus.this_isRunning   = ($urandom_range(0, 3) != 0);
            bus.thisOrderAddress = $urandom;
            nx_ask = 1'b0;
            clr    = '0;
            if (m_ask) begin
                clr[m_num[3:0]] = 1'b1;
                m_free = n + HOLDOFF;
            end else if (m_wait) begin
                if (!bus.sys[0]) begin
                    m_wait = 1'b0;
                end else if (!bus.pc_stop && bus.this_isRunning) begin
                    nx_ask = 1'b1;
                    m_wait = 1'b0;
                    m_num  = 8'(m_sel);
                    m_pc   = VEC_BASE + 32'(m_sel) * 32'd4;
                    m_ipc  = bus.thisOrderAddress;
                end
            end else if (n >= m_free && bus.sys[0] && (m_pend & m_mask) != 16'h0) begin
                e = m_pend & m_mask;
                for (int i = 15; i >= 0; i--) if (e[i]) m_sel = i;
                m_wait = 1'b1;
            end
            m_pend = (m_pend & ~clr) | (bus.irq_line & ~m_prev);
            m_prev = bus.irq_line;
            if (bus.mask_wr) m_mask = bus.mask_wdata;
            m_ask = nx_ask;
            tick();
            checks++; if (bus.interrupt_ask !== m_ask) begin errors++; $display("FAIL rnd_ask cyc %0d: got %b expected %b", n, bus.interrupt_ask, m_ask); end
            checks++; if (bus.pending !== m_pend) begin errors++; $display("FAIL rnd_pending cyc %0d: got %h expected %h", n, bus.pending, m_pend); end
            checks++; if (bus.interrupt_num !== m_num) begin errors++; $display("FAIL rnd_num cyc %0d: got %0d expected %0d", n, bus.interrupt_num, m_num); end
            checks++; if (bus.interrupt_pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d: got %h expected %h", n, bus.interrupt_pc, m_pc); end
            checks++; if (bus.interrupt_ipc !== m_ipc) begin errors++; $display("FAIL rnd_ipc cyc %0d: got %h expected %h", n, bus.interrupt_ipc, m_ipc); end
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_simultaneous();
        test_stall();
        test_masking();
        test_global_disable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h00000100: base address of the interrupt vector table.
REQ-002 SHALL have parameter HOLDOFF, default 2: number of cycles blocked after each grant.
REQ-003 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have all_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have irq_line, input, 16: external interrupt sources, synchronous to clk, rising-edge sensitive.
REQ-006 SHALL have mask_wr, input, 1, and mask_wdata, input, 16: write strobe and data for the enable mask (1 = line enabled).
REQ-007 SHALL have sys, input, 32: current sys register value; bit 0 is the global interrupt enable.
REQ-008 SHALL have pc_stop and this_isRunning, input, 1 each: pipeline stall flag and valid-instruction flag.
REQ-009 SHALL have thisOrderAddress, input, 32: address of the instruction at the current pipeline point.
REQ-010 SHALL have interrupt_ask, output, 1: single-cycle grant pulse to the register group.
REQ-011 SHALL have interrupt_pc and interrupt_ipc, output, 32 each: vector address and return address.
REQ-012 SHALL have interrupt_num, output, 8: number of the granted interrupt.
REQ-013 SHALL have pending, output, 16: current pending bits, for status.

Function
REQ-014 SHALL register irq_line every cycle and set pending[i] when irq_line[i] is 1 and its previous sample is 0.
REQ-015 SHALL treat line i as eligible when pending[i] is 1 and mask[i] is 1.
  - Masked lines still latch pending.
  - Lowest eligible index wins.
REQ-016 SHALL update mask on any cycle with mask_wr = 1, effective the next cycle.
REQ-017 SHALL use a four-state FSM: IDLE, ARM, ASK, HOLD.
REQ-018 SHALL behave in IDLE as follows: if any line is eligible and sys[0] = 1, latch the winning index into interrupt_num and go to ARM.
REQ-019 SHALL behave in ARM as follows:
  - If sys[0] = 0, go to IDLE with pending unchanged.
  - Else, if pc_stop = 0 and this_isRunning = 1 (safe point), capture thisOrderAddress into interrupt_ipc and go to ASK.
  - Else stay in ARM.
REQ-020 SHALL behave in ASK as follows:
  - Drive interrupt_ask = 1 for exactly that cycle.
  - Drive interrupt_pc = VEC_BASE + {interrupt_num, 2'b00}, 32-bit wrap-around.
  - Clear pending[interrupt_num].
  - Go to HOLD.
REQ-021 SHALL stay in HOLD for HOLDOFF cycles with interrupt_ask = 0, then return to IDLE; no new ARM entry is allowed during HOLD.
REQ-022 SHALL keep pending set if a new rising edge on a line coincides with its clear in ASK (set wins).
REQ-023 SHALL keep the latched interrupt_num in ARM even if a higher-priority line becomes eligible meanwhile; that line is served next.
REQ-024 SHALL give a grant latency of 2 cycles from the edge-set cycle to interrupt_ask when the pipeline is safe immediately.
REQ-025 SHALL hold interrupt_pc, interrupt_ipc and interrupt_num stable from ASK until the next ASK.

Reset
REQ-026 SHALL, while all_rst_n = 0, asynchronously force:
  - state IDLE, all pending and edge history 0;
  - mask 16'hFFFF, HOLD counter 0;
  - interrupt_ask 0, interrupt_pc 0, interrupt_ipc 0, interrupt_num 0.
REQ-027 SHALL abort any ARM/ASK/HOLD sequence when reset asserts mid-operation, with no interrupt_ask pulse emitted.

Configuration
REQ-028 SHALL, with SOFT_IRQ_EN defined, add inputs sw_irq (1) and sw_irq_num (8) for a software interrupt:
  - A sw_irq pulse sets one sw_pending flag and stores sw_irq_num.
  - sw_pending is eligible, unmasked, with priority below all 16 lines.
  - It is served through the same FSM and cleared in ASK.
  - A sw_irq while sw_pending is set overwrites the stored number.
REQ-029 SHALL, without SOFT_IRQ_EN, omit those ports and that logic entirely.

Structure
REQ-030 SHALL place the FSM state encoding, the line count (16) and the vector shift (2) in shared package cpu_core_pkg.
REQ-031 SHALL implement the lowest-index priority encoder as sub-module irq_prio_enc16 (pending&mask in; valid and 4-bit index out).

Verification
REQ-032 SHALL cover a single grant:
  - Stimulus: sys=1, rising edge on irq_line[3], pipeline safe.
  - Response: interrupt_ask pulses 2 cycles later, interrupt_num=3, interrupt_pc=32'h0000010C, pending[3] cleared.
REQ-033 SHALL cover simultaneous edges:
  - Stimulus: edges on lines 5 and 2 together.
  - Response: line 2 granted first; line 5 granted HOLDOFF+2 cycles after the first grant.
REQ-034 SHALL cover stall:
  - Stimulus: pc_stop held 1 for 4 cycles in ARM, thisOrderAddress=32'h00010040 on release.
  - Response: ask one cycle after release, interrupt_ipc=32'h00010040.
REQ-035 SHALL cover masking:
  - Stimulus: mask written to 16'h0000, edge on line 0.
  - Response: pending[0]=1, no ask; after mask_wr of 16'h0001, ask with num 0.
REQ-036 SHALL cover global disable:
  - Stimulus: sys[0] drops while in ARM.
  - Response: FSM returns to IDLE, no ask, pending retained; grant resumes when sys[0]=1.
REQ-037 SHALL cover reset mid-operation:
  - Stimulus: all_rst_n pulsed low while in ARM.
  - Response: all outputs 0 immediately, pending=0, no ask after release.
